// File: rtl/dmem_mmio.sv
// dmem_mmio
// Data-side responder for the single-cycle RISC-V core. It serves the core's
// data-memory port from a word-addressed RAM or from a small MMIO block.
// The MMIO block holds an LED register, a free-running cycle counter and a
// compare timer with a sticky match flag. Reads are combinational and writes
// commit on the rising clock edge.
//
// Ports
//   clk        in   1   single clock, rising edge
//   reset      in   1   asynchronous, active-low
//   MemWrite   in   1   write strobe from the core
//   DataAdr    in  32   byte address; bit 31 selects MMIO (1) or RAM (0)
//   WriteData  in  32   store data
//   ReadData   out 32   load data, combinational
//   Leds       out  8   LED register
//   TimerIrq   out  1   sticky compare-match flag
//
// MMIO map (offset = DataAdr[7:0], bits [1:0] ignored)
//   0x00 LED     RW   [7:0]
//   0x04 CYCLE   RO   free-running 32-bit counter
//   0x08 CMP     RW   compare value
//   0x0C STATUS       bit0 FLAG (RO, write 1 to clear), bit1 EN (RW)
module dmem_mmio #(
    parameter int    DEPTH   = 64,
    parameter string MEMFILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  Leds,
    output logic        TimerIrq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [7:0]    r_led;
    logic [31:0]   r_cycle;
    logic [31:0]   r_cmp;
    logic          r_flag;
    logic          r_en;

    logic [AW-1:0] w_idx;
    logic          w_sel_mmio;
    logic          w_ram_we;
    logic          w_wr_led;
    logic          w_wr_cmp;
    logic          w_wr_stat;
    logic          w_match;
    logic [31:0]   w_rdata;
    logic          w_unused_ok;

    assign w_idx      = DataAdr[AW+1:2];
    assign w_sel_mmio = DataAdr[31];

    // Qualifying the RAM write with reset drops any store issued while
    // reset is held, even though the RAM itself is never cleared.
    assign w_ram_we  = MemWrite && !w_sel_mmio && reset;
    assign w_wr_led  = MemWrite && w_sel_mmio && (DataAdr[7:2] == 6'h00);
    assign w_wr_cmp  = MemWrite && w_sel_mmio && (DataAdr[7:2] == 6'h02);
    assign w_wr_stat = MemWrite && w_sel_mmio && (DataAdr[7:2] == 6'h03);

    // Match uses register values from before this edge, so a same-edge
    // write to CMP or EN does not influence it.
    assign w_match = r_en && (r_cycle == r_cmp);

    assign w_unused_ok = &{1'b0, DataAdr[30:8], DataAdr[1:0]};

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led   <= 8'h00;
            r_cycle <= 32'h0000_0000;
            r_cmp   <= 32'hFFFF_FFFF;
            r_flag  <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_led) begin
                r_led <= WriteData[7:0];
            end
            if (w_wr_cmp) begin
                r_cmp <= WriteData;
            end
            if (w_wr_stat) begin
                r_en <= WriteData[1];
            end
            // A new match beats a simultaneous write-1-to-clear.
            if (w_match) begin
                r_flag <= 1'b1;
            end else if (w_wr_stat && WriteData[0]) begin
                r_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = 32'h0000_0000;
        if (!w_sel_mmio) begin
            w_rdata = r_mem[w_idx];
        end else begin
            case (DataAdr[7:2])
                6'h00:   w_rdata = {24'h000000, r_led};
                6'h01:   w_rdata = r_cycle;
                6'h02:   w_rdata = r_cmp;
                6'h03:   w_rdata = {30'h0, r_en, r_flag};
                default: w_rdata = 32'h0000_0000;
            endcase
        end
    end

    assign ReadData = w_rdata;
    assign Leds     = r_led;
    assign TimerIrq = r_flag;

endmodule

// File: tb/tb_dmem_mmio.sv
// Testbench for dmem_mmio: one bus cycle per task call, inputs driven just
// after the rising edge, outputs sampled on the falling edge.
module tb_dmem_mmio;

    localparam logic [31:0] A_LED  = 32'h8000_0000;
    localparam logic [31:0] A_CYC  = 32'h8000_0004;
    localparam logic [31:0] A_CMP  = 32'h8000_0008;
    localparam logic [31:0] A_STAT = 32'h8000_000C;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  Leds;
    logic        TimerIrq;

    int          n_checks;
    int          n_errors;
    logic [31:0] m_cyc;
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] tgt;

    dmem_mmio #(.DEPTH(64), .MEMFILE("")) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Leds      (Leds),
        .TimerIrq  (TimerIrq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle counter: value the CYCLE register should hold now.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_cyc <= 32'h0;
        else        m_cyc <= m_cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle. Expected read data is queued when the access is driven
    // and compared when ReadData is sampled on the falling edge.
    task automatic cyc(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                       input bit do_chk, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        if (do_chk) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, ReadData, e);
        end
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
        cyc(1'b1, adr, wd, 1'b0, 32'h0, "");
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        cyc(1'b0, adr, 32'h0, 1'b1, exp, tag);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "");
    endtask

    task automatic wait_until(input logic [31:0] t);
        for (int i = 0; i < 100 && m_cyc != t; i++) idle();
        chk("wait_tgt", m_cyc, t);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = A_CMP;
        WriteData = 32'h0;

        // Reset state
        #12;
        chk("rst_leds", {24'h0, Leds}, 32'h0);
        chk("rst_irq", {31'h0, TimerIrq}, 32'h0);
        chk("rst_cmp", ReadData, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd(A_CYC, 32'd0, "cycle_first");
        rd(A_CYC, 32'd1, "cycle_second");
        rd(A_CMP, 32'hFFFF_FFFF, "cmp_reset");

        // RAM: write, wrap, byte-offset ignore, read-during-write
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
        rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_wrap");
        rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_byteoff");
        cyc(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, "ram_rdw_old");
        rd(32'h0000_0010, 32'h1234_5678, "ram_rdw_new");
        wr(32'h0000_0014, 32'hCAFE_0001);
        rd(32'h0000_0014, 32'hCAFE_0001, "ram_w5");
        rd(32'h0000_0010, 32'h1234_5678, "ram_w4_kept");

        // LED, read-only CYCLE, unmapped offsets, ignored high bits
        wr(A_LED, 32'h0000_01A5);
        chk("leds_a5", {24'h0, Leds}, 32'h0000_00A5);
        rd(A_LED, 32'h0000_00A5, "led_rd");
        wr(A_CYC, 32'h0000_0000);
        rd(A_CYC, m_cyc, "cycle_ro");
        wr(32'h8000_0010, 32'hFFFF_FFFF);
        rd(32'h8000_0010, 32'h0, "unmapped");
        rd(32'hFFFF_FF00, 32'h0000_00A5, "mmio_hibits");

        // Timer: flag rises at the edge where CYCLE==CMP and stays high
        tgt = m_cyc + 32'd8;
        wr(A_CMP, tgt);
        rd(A_CMP, tgt, "cmp_rd");
        wr(A_STAT, 32'h2);
        for (int i = 0; i < 12; i++) begin
            rd(A_STAT, {30'h0, 1'b1, (m_cyc > tgt)}, "stat_match");
        end
        chk("irq_set", {31'h0, TimerIrq}, 32'h1);
        wr(A_STAT, 32'h3);
        chk("irq_w1c", {31'h0, TimerIrq}, 32'h0);
        rd(A_STAT, 32'h2, "stat_after_w1c");

        // W1C on the same edge as a match: set wins
        tgt = m_cyc + 32'd4;
        wr(A_CMP, tgt);
        wait_until(tgt);
        wr(A_STAT, 32'h3);
        chk("irq_set_wins", {31'h0, TimerIrq}, 32'h1);

        // CMP write on the match edge: old CMP is used
        wr(A_STAT, 32'h3);
        chk("irq_clr2", {31'h0, TimerIrq}, 32'h0);
        tgt = m_cyc + 32'd3;
        wr(A_CMP, tgt);
        wait_until(tgt);
        wr(A_CMP, 32'h0);
        chk("irq_old_cmp", {31'h0, TimerIrq}, 32'h1);

        // EN turned on at the match edge: old EN (0) is used
        wr(A_STAT, 32'h1);
        chk("irq_clr3", {31'h0, TimerIrq}, 32'h0);
        tgt = m_cyc + 32'd3;
        wr(A_CMP, tgt);
        wait_until(tgt);
        wr(A_STAT, 32'h2);
        chk("irq_old_en", {31'h0, TimerIrq}, 32'h0);

        // EN=0 with CYCLE==CMP: no flag
        wr(A_STAT, 32'h0);
        tgt = m_cyc + 32'd3;
        wr(A_CMP, tgt);
        wait_until(tgt);
        idle();
        idle();
        chk("irq_en0", {31'h0, TimerIrq}, 32'h0);

        // Set up LED/FLAG/RAM, then assert reset mid-cycle
        wr(A_LED, 32'h0000_003C);
        wr(32'h0000_0010, 32'h0000_0055);
        wr(A_STAT, 32'h2);
        tgt = m_cyc + 32'd3;
        wr(A_CMP, tgt);
        wait_until(tgt);
        idle();
        chk("irq_pre_rst", {31'h0, TimerIrq}, 32'h1);
        wr(A_STAT, 32'h0);
        chk("irq_en_clr_keeps", {31'h0, TimerIrq}, 32'h1);
        chk("leds_3c", {24'h0, Leds}, 32'h0000_003C);

        MemWrite  = 1'b1;
        DataAdr   = 32'h0000_0010;
        WriteData = 32'h0000_0099;
        #2;
        reset = 1'b0;
        #1;
        chk("async_leds", {24'h0, Leds}, 32'h0);
        chk("async_irq", {31'h0, TimerIrq}, 32'h0);
        @(posedge clk);
        #1;
        DataAdr   = A_LED;
        WriteData = 32'h0000_00FF;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        DataAdr  = A_CMP;
        #1;
        chk("rst_cmp2", ReadData, 32'hFFFF_FFFF);
        chk("rst_leds2", {24'h0, Leds}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd(A_CYC, 32'd0, "cycle_after_rst");
        rd(32'h0000_0010, 32'h0000_0055, "ram_survives");
        rd(A_STAT, 32'h0, "stat_after_rst");
        rd(A_LED, 32'h0, "led_after_rst");
        rd(A_CYC, 32'd4, "cycle_counting");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
